mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_control_fsm_if.sv | 38 +++
 rtl/mc_control_fsm.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
// The master modport is the controller; the slave modport is the datapath side.
interface mc_control_fsm_if;
  logic [31:0] instr;
  logic        zero;

  logic        PCWrite;
  logic        IorD;
  logic        IRWrite;
  logic        ALUSrcA;
  logic        memToReg;
  logic        memWrite;
  logic        regDst;
  logic        regWriteEnable;
  logic        jump;
  logic        jumpReg;
  logic        branchEnable;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSrc;
  logic [4:0]  ALUControl;
  logic [3:0]  state;
  logic [31:0] instrCount;
  logic        illegal;

  modport master (
    input  instr, zero,
    output PCWrite, IorD, IRWrite, ALUSrcA, memToReg, memWrite, regDst,
           regWriteEnable, jump, jumpReg, branchEnable, ALUSrcB, PCSrc,
           ALUControl, state, instrCount, illegal
  );

  modport slave (
    output instr, zero,
    input  PCWrite, IorD, IRWrite, ALUSrcA, memToReg, memWrite, regDst,
           regWriteEnable, jump, jumpReg, branchEnable, ALUSrcB, PCSrc,
           ALUControl, state, instrCount, illegal
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control FSM with registered Moore outputs and a retire counter.
// Define MC_CONTROL_BNE_EN to decode bne (opcode 000101) through the branch compare states.
module mc_control_fsm (
  input  logic             clock,
  input  logic             resetN,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRCMP  = 4'd8,
    S_BRTAKE = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_JR     = 4'd13,
    S_JAL    = 4'd14
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       ir_write;
    logic       alu_src_a;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_dst;
    logic       reg_write;
    logic       jump;
    logic       jump_reg;
    logic       branch_en;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [4:0] alu_ctrl;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_JR     = 6'b001000;

  localparam logic [4:0] ALU_AND   = 5'b00000;
  localparam logic [4:0] ALU_OR    = 5'b00001;
  localparam logic [4:0] ALU_ADD   = 5'b00010;
  localparam logic [4:0] ALU_SUB   = 5'b00110;
  localparam logic [4:0] ALU_SLT   = 5'b00111;
  localparam logic [4:0] ALU_PASSA = 5'b01000;

  // Returns {supported, alu_op}; unsupported functs fall back to ADD.
  function automatic logic [5:0] funct_to_alu(input logic [5:0] f);
    logic [5:0] r;
    case (f)
      6'b100000: r = {1'b1, ALU_ADD};
      6'b100010: r = {1'b1, ALU_SUB};
      6'b100100: r = {1'b1, ALU_AND};
      6'b100101: r = {1'b1, ALU_OR};
      6'b101010: r = {1'b1, ALU_SLT};
      default:   r = {1'b0, ALU_ADD};
    endcase
    return r;
  endfunction

  function automatic ctrl_t decode_ctrl(input state_e s, input logic [4:0] r_op);
    ctrl_t c;
    c          = '0;
    c.alu_ctrl = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR, S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord      = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = r_op;
      end
      S_ALUWB: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = r_op;
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRCMP: begin
        c.alu_src_a = 1'b1;
        c.alu_ctrl  = ALU_SUB;
        c.branch_en = 1'b1;
      end
      S_BRTAKE: begin
        c.pc_write  = 1'b1;
        c.alu_src_b = 2'b11;
      end
      S_ADDIWB: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.reg_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_JR: begin
        c.pc_write = 1'b1;
        c.jump_reg = 1'b1;
        c.pc_src   = 2'b10;
      end
      S_JAL: begin
        c.reg_write = 1'b1;
        c.jump      = 1'b1;
        c.pc_write  = 1'b1;
        c.alu_ctrl  = ALU_PASSA;
        c.pc_src    = 2'b10;
      end
      default: ;
    endcase
    return c;
  endfunction

  state_e      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        illegal_q, illegal_d;
  logic        taken_q, taken_d;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        alu_ok;
  logic [4:0]  alu_op;
  logic        br_taken;
  logic        retire;
  logic        unused_instr_bits;

  assign opcode            = bus.instr[31:26];
  assign funct             = bus.instr[5:0];
  assign unused_instr_bits = ^bus.instr[25:6];
  assign {alu_ok, alu_op}  = funct_to_alu(funct);

`ifdef MC_CONTROL_BNE_EN
  assign br_taken = (opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
  assign br_taken = bus.zero;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    taken_d   = taken_q;
    retire    = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = (funct == F_JR) ? S_JR : S_EXEC;
          OP_BEQ:       state_d = S_BRCMP;
`ifdef MC_CONTROL_BNE_EN
          OP_BNE:       state_d = S_BRCMP;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC: begin
        if (alu_ok) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_BRCMP: begin
        taken_d = br_taken;
        if (br_taken) begin
          state_d = S_BRTAKE;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_BRTAKE: begin
        // Only reachable with the flag set; it still qualifies the retire.
        state_d = S_FETCH;
        retire  = taken_q;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_JUMP, S_JR, S_JAL: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase

    instr_count_d = instr_count_q + {31'd0, retire};
    // Outputs are decoded from the next state so they line up with state_q after the edge.
    ctrl_d        = decode_ctrl(state_d, alu_op);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= S_FETCH;
      ctrl_q        <= decode_ctrl(S_FETCH, ALU_ADD);
      instr_count_q <= '0;
      illegal_q     <= 1'b0;
      taken_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      instr_count_q <= instr_count_d;
      illegal_q     <= illegal_d;
      taken_q       <= taken_d;
    end
  end

  assign bus.PCWrite        = ctrl_q.pc_write;
  assign bus.IorD           = ctrl_q.iord;
  assign bus.IRWrite        = ctrl_q.ir_write;
  assign bus.ALUSrcA        = ctrl_q.alu_src_a;
  assign bus.memToReg       = ctrl_q.mem_to_reg;
  assign bus.memWrite       = ctrl_q.mem_write;
  assign bus.regDst         = ctrl_q.reg_dst;
  assign bus.regWriteEnable = ctrl_q.reg_write;
  assign bus.jump           = ctrl_q.jump;
  assign bus.jumpReg        = ctrl_q.jump_reg;
  assign bus.branchEnable   = ctrl_q.branch_en;
  assign bus.ALUSrcB        = ctrl_q.alu_src_b;
  assign bus.PCSrc          = ctrl_q.pc_src;
  assign bus.ALUControl     = ctrl_q.alu_ctrl;
  assign bus.state          = state_q;
  assign bus.instrCount     = instr_count_q;
  assign bus.illegal        = illegal_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: a per-cycle vector table plus reset, bne and wrap sequences.
// Control word order: {PCWrite,IorD,IRWrite,ALUSrcA,memToReg,memWrite,regDst,regWriteEnable,jump,jumpReg,branchEnable,ALUSrcB,PCSrc,ALUControl}.
module tb_mc_control_fsm;

  logic clock;
  logic resetN;
  int   n_tests;
  int   n_fail;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  state;
    logic [19:0] ctrl;
    logic [31:0] cnt;
    logic        ill;
  } vec_t;

  localparam logic [4:0] A_AND = 5'b00000, A_OR = 5'b00001, A_ADD = 5'b00010;
  localparam logic [4:0] A_SUB = 5'b00110, A_SLT = 5'b00111, A_PASSA = 5'b01000;

  localparam logic [19:0] K_FETCH  = {11'b10100000000, 2'b01, 2'b00, A_ADD};
  localparam logic [19:0] K_DECODE = {11'b00000000000, 2'b00, 2'b00, A_ADD};
  localparam logic [19:0] K_MEMADR = {11'b00010000000, 2'b10, 2'b00, A_ADD};
  localparam logic [19:0] K_MEMRD  = {11'b01010000000, 2'b10, 2'b00, A_ADD};
  localparam logic [19:0] K_MEMWB  = {11'b00001001000, 2'b00, 2'b00, A_ADD};
  localparam logic [19:0] K_MEMWR  = {11'b01010100000, 2'b10, 2'b00, A_ADD};
  localparam logic [19:0] K_BRCMP  = {11'b00010000001, 2'b00, 2'b00, A_SUB};
  localparam logic [19:0] K_BRTAKE = {11'b10000000000, 2'b11, 2'b00, A_ADD};
  localparam logic [19:0] K_ADDIEX = {11'b00010000000, 2'b10, 2'b00, A_ADD};
  localparam logic [19:0] K_ADDIWB = {11'b00010001000, 2'b10, 2'b00, A_ADD};
  localparam logic [19:0] K_JUMP   = {11'b10000000000, 2'b00, 2'b10, A_ADD};
  localparam logic [19:0] K_JR     = {11'b10000000010, 2'b00, 2'b10, A_ADD};
  localparam logic [19:0] K_JAL    = {11'b10000001100, 2'b00, 2'b10, A_PASSA};

  localparam logic [31:0] I_LW   = 32'h8C020004, I_SW   = 32'hAC020008;
  localparam logic [31:0] I_ADD  = 32'h00430820, I_SUB  = 32'h00430822;
  localparam logic [31:0] I_AND  = 32'h00430824, I_OR   = 32'h00430825;
  localparam logic [31:0] I_SLT  = 32'h0043082A, I_BEQ  = 32'h10430003;
  localparam logic [31:0] I_ADDI = 32'h20420005, I_J    = 32'h08000010;
  localparam logic [31:0] I_JR   = 32'h03E00008, I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_BADF = 32'h00430821, I_BNE  = 32'h14430003;
  localparam logic [31:0] I_LUI  = 32'h3C010001;

  function automatic logic [19:0] k_exec(input logic [4:0] a);
    return {11'b00010000000, 2'b00, 2'b00, a};
  endfunction

  function automatic logic [19:0] k_aluwb(input logic [4:0] a);
    return {11'b00010011000, 2'b00, 2'b00, a};
  endfunction

  function automatic vec_t v(input logic [31:0] i, input logic z, input logic [3:0] s,
                             input logic [19:0] c, input logic [31:0] n, input logic il);
    vec_t r;
    r.instr = i; r.zero = z; r.state = s; r.ctrl = c; r.cnt = n; r.ill = il;
    return r;
  endfunction

  function automatic logic [19:0] dut_ctrl();
    return {bus.PCWrite, bus.IorD, bus.IRWrite, bus.ALUSrcA, bus.memToReg, bus.memWrite,
            bus.regDst, bus.regWriteEnable, bus.jump, bus.jumpReg, bus.branchEnable,
            bus.ALUSrcB, bus.PCSrc, bus.ALUControl};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_now(input string tag, input vec_t e);
    check({tag, " state"}, {28'd0, bus.state}, {28'd0, e.state});
    check({tag, " ctrl"}, {12'd0, dut_ctrl()}, {12'd0, e.ctrl});
    check({tag, " instrCount"}, bus.instrCount, e.cnt);
    check({tag, " illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
  endtask

  // Drive inputs, take one rising edge, then compare outputs shortly after it.
  task automatic apply(input string tag, input vec_t e);
    bus.instr = e.instr;
    bus.zero  = e.zero;
    @(posedge clock);
    #1;
    check_now(tag, e);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    resetN    = 1'b1;
    bus.instr = I_LW;
    bus.zero  = 1'b0;

    // lw, sw, five R-types, beq taken / not taken, addi, j, jr, jal, bad funct, sticky illegal.
    vecs.push_back(v(I_LW, 0, 1, K_DECODE, 0, 0));
    vecs.push_back(v(I_LW, 0, 2, K_MEMADR, 0, 0));
    vecs.push_back(v(I_LW, 0, 3, K_MEMRD,  0, 0));
    vecs.push_back(v(I_LW, 0, 4, K_MEMWB,  0, 0));
    vecs.push_back(v(I_LW, 0, 0, K_FETCH,  1, 0));
    vecs.push_back(v(I_SW, 0, 1, K_DECODE, 1, 0));
    vecs.push_back(v(I_SW, 0, 2, K_MEMADR, 1, 0));
    vecs.push_back(v(I_SW, 0, 5, K_MEMWR,  1, 0));
    vecs.push_back(v(I_SW, 0, 0, K_FETCH,  2, 0));
    vecs.push_back(v(I_ADD, 0, 1, K_DECODE,       2, 0));
    vecs.push_back(v(I_ADD, 0, 6, k_exec(A_ADD),  2, 0));
    vecs.push_back(v(I_ADD, 0, 7, k_aluwb(A_ADD), 2, 0));
    vecs.push_back(v(I_ADD, 0, 0, K_FETCH,        3, 0));
    vecs.push_back(v(I_SUB, 0, 1, K_DECODE,       3, 0));
    vecs.push_back(v(I_SUB, 0, 6, k_exec(A_SUB),  3, 0));
    vecs.push_back(v(I_SUB, 0, 7, k_aluwb(A_SUB), 3, 0));
    vecs.push_back(v(I_SUB, 0, 0, K_FETCH,        4, 0));
    vecs.push_back(v(I_AND, 0, 1, K_DECODE,       4, 0));
    vecs.push_back(v(I_AND, 0, 6, k_exec(A_AND),  4, 0));
    vecs.push_back(v(I_AND, 0, 7, k_aluwb(A_AND), 4, 0));
    vecs.push_back(v(I_AND, 0, 0, K_FETCH,        5, 0));
    vecs.push_back(v(I_OR,  0, 1, K_DECODE,       5, 0));
    vecs.push_back(v(I_OR,  0, 6, k_exec(A_OR),   5, 0));
    vecs.push_back(v(I_OR,  0, 7, k_aluwb(A_OR),  5, 0));
    vecs.push_back(v(I_OR,  0, 0, K_FETCH,        6, 0));
    vecs.push_back(v(I_SLT, 0, 1, K_DECODE,       6, 0));
    vecs.push_back(v(I_SLT, 0, 6, k_exec(A_SLT),  6, 0));
    vecs.push_back(v(I_SLT, 0, 7, k_aluwb(A_SLT), 6, 0));
    vecs.push_back(v(I_SLT, 0, 0, K_FETCH,        7, 0));
    vecs.push_back(v(I_BEQ, 0, 1, K_DECODE, 7, 0));
    vecs.push_back(v(I_BEQ, 0, 8, K_BRCMP,  7, 0));
    vecs.push_back(v(I_BEQ, 1, 9, K_BRTAKE, 7, 0));
    vecs.push_back(v(I_BEQ, 0, 0, K_FETCH,  8, 0));
    vecs.push_back(v(I_BEQ, 0, 1, K_DECODE, 8, 0));
    vecs.push_back(v(I_BEQ, 1, 8, K_BRCMP,  8, 0));
    vecs.push_back(v(I_BEQ, 0, 0, K_FETCH,  9, 0));
    vecs.push_back(v(I_ADDI, 0, 1,  K_DECODE, 9,  0));
    vecs.push_back(v(I_ADDI, 0, 10, K_ADDIEX, 9,  0));
    vecs.push_back(v(I_ADDI, 0, 11, K_ADDIWB, 9,  0));
    vecs.push_back(v(I_ADDI, 0, 0,  K_FETCH,  10, 0));
    vecs.push_back(v(I_J,   0, 1,  K_DECODE, 10, 0));
    vecs.push_back(v(I_J,   0, 12, K_JUMP,   10, 0));
    vecs.push_back(v(I_J,   0, 0,  K_FETCH,  11, 0));
    vecs.push_back(v(I_JR,  0, 1,  K_DECODE, 11, 0));
    vecs.push_back(v(I_JR,  0, 13, K_JR,     11, 0));
    vecs.push_back(v(I_JR,  0, 0,  K_FETCH,  12, 0));
    vecs.push_back(v(I_JAL, 0, 1,  K_DECODE, 12, 0));
    vecs.push_back(v(I_JAL, 0, 14, K_JAL,    12, 0));
    vecs.push_back(v(I_JAL, 0, 0,  K_FETCH,  13, 0));
    vecs.push_back(v(I_BADF, 0, 1, K_DECODE,      13, 0));
    vecs.push_back(v(I_BADF, 0, 6, k_exec(A_ADD), 13, 0));
    vecs.push_back(v(I_BADF, 0, 0, K_FETCH,       13, 1));
    vecs.push_back(v(I_J,   0, 1,  K_DECODE, 13, 1));
    vecs.push_back(v(I_J,   0, 12, K_JUMP,   13, 1));
    vecs.push_back(v(I_J,   0, 0,  K_FETCH,  14, 1));

    // Asynchronous reset: outputs must settle before any rising edge.
    #1 resetN = 1'b0;
    #2 check_now("async reset", v(I_LW, 0, 0, K_FETCH, 0, 0));
    repeat (2) @(posedge clock);
    #1 check_now("held reset", v(I_LW, 0, 0, K_FETCH, 0, 0));
    @(negedge clock);
    resetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // Reset clears the sticky illegal flag and the count.
    do_reset();
    #1 check_now("reset clears", v(I_LW, 0, 0, K_FETCH, 0, 0));

`ifdef MC_CONTROL_BNE_EN
    apply("bne decode", v(I_BNE, 0, 1, K_DECODE, 0, 0));
    apply("bne cmp",    v(I_BNE, 0, 8, K_BRCMP,  0, 0));
    apply("bne take",   v(I_BNE, 0, 9, K_BRTAKE, 0, 0));
    apply("bne fetch",  v(I_BNE, 1, 0, K_FETCH,  1, 0));
    apply("bne2 dec",   v(I_BNE, 1, 1, K_DECODE, 1, 0));
    apply("bne2 cmp",   v(I_BNE, 0, 8, K_BRCMP,  1, 0));
    apply("bne2 fall",  v(I_BNE, 1, 0, K_FETCH,  2, 0));
`else
    apply("bne decode", v(I_BNE, 0, 1, K_DECODE, 0, 0));
    apply("bne illegal", v(I_BNE, 0, 0, K_FETCH, 0, 1));
`endif

    do_reset();
    apply("lui decode",  v(I_LUI, 0, 1, K_DECODE, 0, 0));
    apply("lui illegal", v(I_LUI, 0, 0, K_FETCH,  0, 1));

    // Reset pulled mid-MEMWR aborts the store with no retire.
    do_reset();
    apply("abort dec", v(I_SW, 0, 1, K_DECODE, 0, 0));
    apply("abort adr", v(I_SW, 0, 2, K_MEMADR, 0, 0));
    apply("abort wr",  v(I_SW, 0, 5, K_MEMWR,  0, 0));
    #2 resetN = 1'b0;
    #1 check_now("abort reset", v(I_SW, 0, 0, K_FETCH, 0, 0));
    check("abort memWrite", {31'd0, bus.memWrite}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    apply("first edge fetch", v(I_SW, 0, 1, K_DECODE, 0, 0));

    // Counter wrap: preload all ones, then retire a jump.
    do_reset();
    apply("wrap dec", v(I_J, 0, 1, K_DECODE, 0, 0));
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1 release dut.instr_count_q;
    #1 check("wrap preload", bus.instrCount, 32'hFFFF_FFFF);
    apply("wrap jump",  v(I_J, 0, 12, K_JUMP,  32'hFFFF_FFFF, 0));
    apply("wrap fetch", v(I_J, 0, 0,  K_FETCH, 32'h0000_0000, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
